// File: rtl/na_wb_sched_pkg.sv
// na_wb_sched_pkg: shared FSM encoding, endpoint class type and endpoint register address helper
package na_wb_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_GNT_RD = 3'd1;
    localparam state_t S_GNT_WR = 3'd2;
    localparam state_t S_CFG    = 3'd3;
    localparam state_t S_GAP    = 3'd4;

    typedef enum logic {CLS_BE, CLS_TDM} ep_cls_t;

    function automatic logic [31:0] ep_addr(input logic [31:0] base, input logic [31:0] stride,
                                            input logic [31:0] ofs, input logic [31:0] idx);
        return base + idx * stride + ofs;
    endfunction

endpackage

// File: rtl/na_wb_sched_if.sv
// na_wb_sched_if: Wishbone master port bundle
//   master: drives adr/dat/sel/cyc/stb/we, receives ack/err
//   slave : the reverse
interface na_wb_sched_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        err;
    modport master(output adr, dat, sel, cyc, stb, we, input ack, err);
    modport slave(input adr, dat, sel, cyc, stb, we, output ack, err);
endinterface

// File: rtl/na_wb_sched_watchdog.sv
// na_wb_sched_watchdog: counts unanswered strobe cycles and flags when the limit is reached
//   clk, rst : clock, async active-high reset
//   busy     : strobe outstanding without ack/err this cycle
//   clr      : restart the count (response seen or owner changed)
//   fire     : count has reached TIMEOUT_CYCLES (never set when TIMEOUT_CYCLES is 0)
module na_wb_sched_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic clr,
    output logic fire
);
    localparam int unsigned W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [W-1:0] cnt;

    assign fire = TIMEOUT_CYCLES != 0 && cnt == W'(TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || fire)
            cnt <= '0;
        else if (busy && TIMEOUT_CYCLES != 0)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/na_wb_sched.sv
// na_wb_sched: shares one Wishbone master between read/write engines and sequences endpoint enable writes
//   clk, rst                        : clock, async active-high reset
//   req_rd/req_wr, gnt_rd/gnt_wr    : engine burst requests and registered grants
//   req_*_active, *_active          : requested and confirmed endpoint-class enable state
//   cfg_err, bus_timeout            : one-cycle pulses for a failed enable write / watchdog expiry
//   rd_wb_*, wr_wb_*                : engine-side bus signals muxed onto the master port
//   wb                              : shared Wishbone master port
module na_wb_sched
    import na_wb_sched_pkg::*;
#(
    parameter int unsigned NUM_BE_ENDPOINTS  = 2,
    parameter int unsigned NUM_TDM_ENDPOINTS = 2,
    parameter logic [31:0] EP_BASE_ADDR      = 32'h0,
    parameter logic [31:0] EP_STRIDE         = 32'h2000,
    parameter logic [31:0] EN_REG_OFS        = 32'h4,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    output logic        gnt_rd,
    output logic        gnt_wr,
    input  logic        req_be_active,
    input  logic        req_tdm_active,
    output logic        be_active,
    output logic        tdm_active,
    output logic        cfg_err,
    output logic        bus_timeout,
    input  logic [31:0] rd_wb_adr_i,
    input  logic        rd_wb_cyc_i,
    input  logic        rd_wb_stb_i,
    input  logic [31:0] wr_wb_adr_i,
    input  logic [31:0] wr_wb_dat_i,
    input  logic        wr_wb_cyc_i,
    input  logic        wr_wb_stb_i,
    na_wb_sched_if.master wb
);
    localparam int unsigned IW = $clog2(NUM_BE_ENDPOINTS + NUM_TDM_ENDPOINTS + 1);

    state_t        state, state_n;
    ep_cls_t       cfg_cls;
    logic [IW-1:0] ep_idx;
    logic          last_rd, tdm_flt, be_flt, cfg_val, cyc_q, fire;
    logic          tdm_pend, be_pend, cfg_last;
    logic [31:0]   ep_gidx;

    // a faulted class stays quiet until the host withdraws its request
    assign tdm_pend = (req_tdm_active != tdm_active) && !tdm_flt;
    assign be_pend  = (req_be_active != be_active) && !be_flt;
    assign cfg_last = ep_idx == IW'(cfg_cls == CLS_TDM ? NUM_TDM_ENDPOINTS - 1 : NUM_BE_ENDPOINTS - 1);
    // BE endpoints are numbered after all TDM endpoints
    assign ep_gidx  = cfg_cls == CLS_TDM ? 32'(ep_idx) : 32'(NUM_TDM_ENDPOINTS) + 32'(ep_idx);
    assign gnt_rd      = state == S_GNT_RD;
    assign gnt_wr      = state == S_GNT_WR;
    assign bus_timeout = fire;

    na_wb_sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk  (clk),
        .rst  (rst),
        .busy (wb.cyc && wb.stb && !wb.ack && !wb.err),
        .clr  (wb.ack || wb.err || state_n != state),
        .fire (fire)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = (tdm_pend || be_pend) ? S_CFG :
                                (req_rd && (!req_wr || !last_rd)) ? S_GNT_RD :
                                req_wr ? S_GNT_WR : S_IDLE;
            S_GNT_RD: state_n = (!req_rd || fire) ? S_GAP : S_GNT_RD;
            S_GNT_WR: state_n = (!req_wr || fire) ? S_GAP : S_GNT_WR;
            S_CFG:    state_n = (fire || (cyc_q && (wb.err || (wb.ack && cfg_last)))) ? S_GAP : S_CFG;
            default:  state_n = S_IDLE;
        endcase
    end

    // the bus follows the registered state, so reset idles it immediately
    always_comb begin
        wb.adr = '0;
        wb.dat = '0;
        wb.sel = 4'hF;
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        wb.we  = 1'b0;
        case (state)
            S_GNT_RD: begin
                wb.adr = rd_wb_adr_i;
                wb.cyc = rd_wb_cyc_i;
                wb.stb = rd_wb_stb_i;
            end
            S_GNT_WR: begin
                wb.adr = wr_wb_adr_i;
                wb.dat = wr_wb_dat_i;
                wb.cyc = wr_wb_cyc_i;
                wb.stb = wr_wb_stb_i;
                wb.we  = 1'b1;
            end
            S_CFG: begin
                wb.adr = ep_addr(EP_BASE_ADDR, EP_STRIDE, EN_REG_OFS, ep_gidx);
                wb.dat = {31'b0, cfg_val};
                wb.cyc = cyc_q;
                wb.stb = cyc_q;
                wb.we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_rd    <= 1'b0;
            tdm_active <= 1'b0;
            be_active  <= 1'b0;
            tdm_flt    <= 1'b0;
            be_flt     <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_cls    <= CLS_TDM;
            cfg_val    <= 1'b0;
            cyc_q      <= 1'b0;
            ep_idx     <= '0;
        end else begin
            state   <= state_n;
            cfg_err <= 1'b0;
            if (req_tdm_active == tdm_active) tdm_flt <= 1'b0;
            if (req_be_active == be_active) be_flt <= 1'b0;
            if (state == S_IDLE && (state_n == S_GNT_RD || state_n == S_GNT_WR))
                last_rd <= state_n == S_GNT_RD;
            if (state == S_IDLE && state_n == S_CFG) begin
                cfg_cls <= tdm_pend ? CLS_TDM : CLS_BE;
                cfg_val <= tdm_pend ? req_tdm_active : req_be_active;
                ep_idx  <= '0;
                cyc_q   <= 1'b1;
            end
            if (state == S_CFG) begin
                // a timeout or error response aborts the class and faults it; the later
                // fault-set assignment overrides the withdraw-clear above
                if (fire || (cyc_q && wb.err)) begin
                    cyc_q   <= 1'b0;
                    cfg_err <= 1'b1;
                    if (cfg_cls == CLS_TDM) tdm_flt <= 1'b1;
                    else be_flt <= 1'b1;
                end else if (cyc_q && wb.ack) begin
                    cyc_q <= 1'b0;
                    if (!cfg_last) ep_idx <= ep_idx + 1'b1;
                    else if (cfg_cls == CLS_TDM) tdm_active <= cfg_val;
                    else be_active <= cfg_val;
                end else if (!cyc_q)
                    cyc_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_na_wb_sched.sv
// tb_na_wb_sched: directed and randomized checks of arbitration, enable sequencing, errors, watchdog and reset
module tb_na_wb_sched;
    localparam int          NT     = 2;
    localparam int          NB     = 2;
    localparam logic [31:0] BASE   = 32'h0;
    localparam logic [31:0] STRIDE = 32'h2000;
    localparam logic [31:0] OFS    = 32'h4;
    localparam int          TO     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic req_rd = 1'b0, req_wr = 1'b0, req_be_active = 1'b0, req_tdm_active = 1'b0;
    logic gnt_rd, gnt_wr, be_active, tdm_active, cfg_err, bus_timeout;
    logic [31:0] rd_adr = '0, wr_adr = '0, wr_dat = '0, err_adr = '0;
    logic ack_en = 1'b1, err_arm = 1'b0;

    na_wb_sched_if wb();
    assign wb.err = err_arm && wb.cyc && wb.stb && wb.adr == err_adr;
    assign wb.ack = ack_en && wb.cyc && wb.stb && !wb.err;

    na_wb_sched #(
        .NUM_BE_ENDPOINTS(NB), .NUM_TDM_ENDPOINTS(NT), .EP_BASE_ADDR(BASE),
        .EP_STRIDE(STRIDE), .EN_REG_OFS(OFS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .gnt_rd(gnt_rd), .gnt_wr(gnt_wr),
        .req_be_active(req_be_active), .req_tdm_active(req_tdm_active),
        .be_active(be_active), .tdm_active(tdm_active), .cfg_err(cfg_err), .bus_timeout(bus_timeout),
        .rd_wb_adr_i(rd_adr), .rd_wb_cyc_i(req_rd), .rd_wb_stb_i(req_rd),
        .wr_wb_adr_i(wr_adr), .wr_wb_dat_i(wr_dat), .wr_wb_cyc_i(req_wr), .wr_wb_stb_i(req_wr),
        .wb(wb)
    );

    int checks = 0, errors = 0;
    int ncyc = 0, last_ack = 0, bus_act = 0;
    logic [63:0] cap_q[$];
    logic m_tdm = 1'b0, m_be = 1'b0, m_last_rd = 1'b0;

    always @(posedge clk) ncyc <= ncyc + 1;

    // acknowledged enable writes (any write not owned by the write engine)
    always @(negedge clk) begin
        if (wb.cyc) bus_act <= bus_act + 1;
        if (wb.cyc && wb.stb && wb.ack && wb.we && !gnt_wr) begin
            cap_q.push_back({wb.adr, wb.dat});
            last_ack <= ncyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_addr(input int g);
        return BASE + 32'(g) * STRIDE + OFS;
    endfunction

    // request a class state and compare the enable writes against the endpoint list
    task automatic settle(input logic t, input logic b);
        logic [63:0] exp_q[$];
        int base, rise;
        bit ok;
        base = cap_q.size();
        if (t != m_tdm) for (int i = 0; i < NT; i++) exp_q.push_back({model_addr(i), 31'b0, t});
        if (b != m_be) for (int i = 0; i < NB; i++) exp_q.push_back({model_addr(NT + i), 31'b0, b});
        req_tdm_active = t;
        req_be_active = b;
        ok = 1'b0;
        rise = 0;
        for (int k = 0; k < 80 && !ok; k++) begin
            tick;
            if (tdm_active == t && be_active == b) begin
                ok = 1'b1;
                rise = ncyc;
            end
        end
        chk("settle_done", 64'(ok), 64'd1);
        if (exp_q.size() != 0) chk("flag_after_ack", 64'(rise), 64'(last_ack + 1));
        chk("cfg_write_count", 64'(cap_q.size() - base), 64'(exp_q.size()));
        foreach (exp_q[i])
            chk("cfg_write", (base + i < cap_q.size()) ? cap_q[base + i] : 64'hx, exp_q[i]);
        m_tdm = t;
        m_be = b;
        repeat (3) tick;
    endtask

    task automatic serve(input bit is_rd, input int len);
        tick;
        chk("gnt_first", {gnt_rd, gnt_wr}, is_rd ? 2'b10 : 2'b01);
        chk("mux_adr", wb.adr, is_rd ? rd_adr : wr_adr);
        chk("mux_we_dat", {wb.we, wb.dat, wb.sel}, is_rd ? {1'b0, 32'h0, 4'hF} : {1'b1, wr_dat, 4'hF});
        repeat (len - 1) begin
            tick;
            chk("gnt_hold", {gnt_rd, gnt_wr, wb.cyc}, is_rd ? 3'b101 : 3'b011);
        end
        if (is_rd) req_rd = 1'b0;
        else req_wr = 1'b0;
        tick;
        chk("gnt_release", {gnt_rd, gnt_wr, wb.cyc, wb.stb}, 4'b0);
    endtask

    task automatic round(input logic [1:0] mask, input int l1, input int l2);
        bit both, first_rd;
        both = mask == 2'b11;
        first_rd = both ? !m_last_rd : mask[0];
        rd_adr = $urandom;
        wr_adr = $urandom;
        wr_dat = $urandom;
        req_rd = mask[0];
        req_wr = mask[1];
        serve(first_rd, l1);
        if (both) begin
            tick;
            chk("gap_idle", {gnt_rd, gnt_wr, wb.cyc}, 3'b0);
            serve(!first_rd, l2);
        end
        m_last_rd = both ? !first_rd : first_rd;
        repeat (2) tick;
    endtask

    initial begin
        int base, a0, g, to_at;
        bit ok;
        repeat (2) tick;
        chk("rst_ctrl", {gnt_rd, gnt_wr, be_active, tdm_active, cfg_err, bus_timeout, wb.cyc, wb.stb, wb.we}, 9'b0);
        chk("rst_adr_dat", {wb.adr, wb.dat}, 64'h0);
        chk("rst_sel", wb.sel, 4'hF);
        rst = 1'b0;
        tick;

        // simultaneous requests: rd first from reset, then the tie goes to rd again after wr
        round(2'b11, 3, 2);
        round(2'b11, 2, 1);

        // TDM enable to two endpoints
        settle(1'b1, 1'b0);

        // both classes change while the write engine owns the bus
        wr_adr = 32'h1234_5678;
        wr_dat = 32'hCAFE_0001;
        req_wr = 1'b1;
        tick;
        chk("c_gnt_wr", {gnt_rd, gnt_wr}, 2'b01);
        base = cap_q.size();
        req_tdm_active = 1'b0;
        req_be_active = 1'b1;
        repeat (6) tick;
        chk("c_still_wr", {gnt_wr, wb.we, tdm_active, be_active}, 4'b1110);
        chk("c_no_cfg", 64'(cap_q.size() - base), 64'd0);
        req_wr = 1'b0;
        m_last_rd = 1'b0;
        settle(1'b0, 1'b1);

        // error response on the first BE write
        settle(1'b0, 1'b0);
        err_arm = 1'b1;
        err_adr = model_addr(NT);
        base = cap_q.size();
        req_be_active = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 12 && !ok; k++) begin
            tick;
            ok = cfg_err;
        end
        chk("d_cfg_err", 64'(ok), 64'd1);
        chk("d_be_inactive", be_active, 1'b0);
        tick;
        chk("d_err_pulse", cfg_err, 1'b0);
        a0 = bus_act;
        repeat (12) tick;
        chk("d_no_retry", 64'(bus_act - a0), 64'd0);
        chk("d_no_writes", 64'(cap_q.size() - base), 64'd0);
        chk("d_be_still0", be_active, 1'b0);
        err_arm = 1'b0;
        settle(1'b0, 1'b0);
        settle(1'b0, 1'b1);

        // unanswered read: watchdog after TO strobe cycles
        ack_en = 1'b0;
        rd_adr = 32'h0BAD_0000;
        req_rd = 1'b1;
        tick;
        chk("e_gnt_rd", {gnt_rd, gnt_wr}, 2'b10);
        g = ncyc;
        to_at = -1;
        for (int k = 0; k < 12 && to_at < 0; k++) begin
            if (bus_timeout) to_at = ncyc;
            else tick;
        end
        chk("e_timeout_cycle", 64'(to_at), 64'(g + TO));
        tick;
        chk("e_gap", {gnt_rd, gnt_wr, wb.cyc, wb.stb, bus_timeout}, 5'b0);
        tick;
        chk("e_idle", {gnt_rd, wb.cyc}, 2'b0);
        tick;
        chk("e_regrant", gnt_rd, 1'b1);
        req_rd = 1'b0;
        ack_en = 1'b1;
        m_last_rd = 1'b1;
        repeat (3) tick;

        // asynchronous reset in the middle of an enable sequence
        ack_en = 1'b0;
        req_tdm_active = 1'b1;
        for (int k = 0; k < 10 && !wb.cyc; k++) tick;
        chk("f_cfg_started", {wb.cyc, wb.we}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("f_rst_ctrl", {gnt_rd, gnt_wr, wb.cyc, wb.stb, wb.we, cfg_err, bus_timeout, tdm_active, be_active}, 9'b0);
        chk("f_rst_bus", {wb.adr, wb.dat, wb.sel}, {64'h0, 4'hF});
        req_tdm_active = 1'b0;
        req_be_active = 1'b0;
        ack_en = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        m_tdm = 1'b0;
        m_be = 1'b0;
        m_last_rd = 1'b0;
        repeat (2) tick;
        chk("f_tdm_after_rst", {tdm_active, be_active}, 2'b00);

        // randomized traffic and enable changes
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 2) == 0) settle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            round(2'($urandom_range(1, 3)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
